// File: rtl/dispatch_ctrl_pkg.sv
// dispatch_ctrl_pkg: system size defines and shared control-state type
`ifndef SYS_DEFS_VH
`define SYS_DEFS_VH
`define ROB_SIZE 16
`define RS_SIZE 8
`define FL_SIZE 32
`endif

package dispatch_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } ctrl_state_e;
endpackage

// File: rtl/dispatch_ctrl_credit_ctr.sv
// credit_ctr: saturating up/down credit counter with snapshot load and overflow flag
module credit_ctr #(
    parameter int SIZE = 16,
    localparam int W = $clog2(SIZE) + 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         ovf
);
    localparam logic [W-1:0] MAX = W'(SIZE);

    assign ovf = load ? (load_val > MAX) : (en & inc & !dec & (count == MAX));

    // load wins over counting; a lone release at full credit is held at MAX
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            count <= MAX;
        else if (load)
            count <= (load_val > MAX) ? MAX : load_val;
        else if (en)
            count <= (inc & !dec) ? ((count == MAX) ? count : count + 1'b1) :
                     (dec & !inc) ? count - 1'b1 : count;
endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: dispatch hazard detection, credit tracking and mispredict recovery FSM
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int ROB_SIZE = `ROB_SIZE,
    parameter int RS_SIZE = `RS_SIZE,
    parameter int FL_SIZE = `FL_SIZE,
    parameter int FLUSH_CYCLES = 2,
    localparam int ROB_W = $clog2(ROB_SIZE) + 1,
    localparam int RS_W = $clog2(RS_SIZE) + 1,
    localparam int FL_W = $clog2(FL_SIZE) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iq_valid,
    input  logic             iq_full,
    input  logic             inst_needs_dest,
    input  logic             rob_retire,
    input  logic             rs_issue,
    input  logic             fl_return,
    input  logic             branch_mispredict,
    input  logic             recover_done,
    input  logic [ROB_W-1:0] rob_free_in,
    input  logic [RS_W-1:0]  rs_free_in,
    input  logic [FL_W-1:0]  fl_free_in,
    output logic             dispatch_no_hazard,
    output logic             fetch_en,
    output logic             branch_incorrect,
    output logic [ROB_W-1:0] rob_free,
    output logic [RS_W-1:0]  rs_free,
    output logic [FL_W-1:0]  fl_free,
    output logic [1:0]       ctrl_state,
    output logic             proto_err
);
    ctrl_state_e state;
    logic [2:0]  flush_cnt;
    logic        run;
    logic        load;
    logic        rob_ovf;
    logic        rs_ovf;
    logic        fl_ovf;

    assign run = (state == RUN);
    assign load = (state == RECOVER) & recover_done & !branch_mispredict;
    assign ctrl_state = state;
    assign dispatch_no_hazard = run & iq_valid & !branch_mispredict & (|rob_free) & (|rs_free) &
                                (!inst_needs_dest | (|fl_free));
    assign fetch_en = run & !iq_full & !branch_mispredict;

    credit_ctr #(.SIZE(ROB_SIZE)) u_rob (
        .clock(clock), .reset(reset), .en(run), .inc(rob_retire), .dec(dispatch_no_hazard),
        .load(load), .load_val(rob_free_in), .count(rob_free), .ovf(rob_ovf)
    );

    credit_ctr #(.SIZE(RS_SIZE)) u_rs (
        .clock(clock), .reset(reset), .en(run), .inc(rs_issue), .dec(dispatch_no_hazard),
        .load(load), .load_val(rs_free_in), .count(rs_free), .ovf(rs_ovf)
    );

    credit_ctr #(.SIZE(FL_SIZE)) u_fl (
        .clock(clock), .reset(reset), .en(run), .inc(fl_return),
        .dec(dispatch_no_hazard & inst_needs_dest),
        .load(load), .load_val(fl_free_in), .count(fl_free), .ovf(fl_ovf)
    );

    // recovery FSM: any mispredict (re)starts FLUSH, FLUSH counts down into RECOVER
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= RUN;
            flush_cnt <= '0;
            branch_incorrect <= 1'b0;
        end else begin
            branch_incorrect <= branch_mispredict;
            if (branch_mispredict) begin
                state <= FLUSH;
                flush_cnt <= 3'(FLUSH_CYCLES);
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt - 3'd1;
                if (flush_cnt == 3'd1)
                    state <= RECOVER;
            end else if (load) begin
                state <= RUN;
            end
        end

    // sticky error: credit overflow or recover_done outside RECOVER
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            proto_err <= 1'b0;
        else
            proto_err <= proto_err | rob_ovf | rs_ovf | fl_ovf | (recover_done & (state != RECOVER));
endmodule
